// File: rtl/min_pkg.sv
// MIN framing package: byte constants, CRC-32 parameters and the frame state encoding
// shared by min_receive_fsm and min_transmit_fsm.
package min_pkg;

   localparam logic [7:0] HdrByte   = 8'hAA;
   localparam logic [7:0] EofByte   = 8'h55;
   localparam logic [7:0] StuffByte = 8'h55;

   localparam logic [31:0] CrcPoly     = 32'h04C11DB7;
   localparam logic [31:0] CrcPolyRefl = 32'hEDB88320;
   localparam logic [31:0] CrcInit     = 32'hFFFFFFFF;
   localparam logic [31:0] CrcXorOut   = 32'hFFFFFFFF;

   typedef enum logic [3:0] {
      StHunt,
      StId,
      StLen,
      StData,
      StCrc0,
      StCrc1,
      StCrc2,
      StCrc3,
      StEof
   } min_state_e;

endpackage

// File: rtl/min_crc32_byte.sv
// Combinational CRC-32 (reflected) update over one byte, LSB first.
module min_crc32_byte
   import min_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_crc
);

   // Eight serial shift/XOR steps unrolled into one cycle
   always_comb begin
      o_crc = i_crc ^ {24'd0, i_byte};
      for (int b = 0; b < 8; b++) begin
         o_crc = o_crc[0] ? ((o_crc >> 1) ^ CrcPolyRefl) : (o_crc >> 1);
      end
   end

endmodule

// File: rtl/min_receive_fsm.sv
// MIN receive framer: header hunt, de-stuffing, length/CRC/EOF checks, validated frame strobe.
// Optional: define MIN_RX_CRC_EN to check the CRC-32; otherwise the CRC bytes are consumed
// and ignored and a frame is good iff its EOF byte is 0x55.
module min_receive_fsm
   import min_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic                     i_valid,
   input  logic [7:0]               i_data,
   output logic                     o_frame_valid,
   output logic                     o_frame_err,
   output logic [5:0]               o_id,
   output logic [7:0]               o_len,
   output logic [8*MAX_PAYLOAD-1:0] o_payload,
   output logic                     o_busy
);

   localparam int unsigned PayloadW = 8 * MAX_PAYLOAD;
   localparam logic [7:0]  MaxLen   = 8'(MAX_PAYLOAD);

   min_state_e          state_q;
   logic [1:0]          aa_cnt_q;
   logic [5:0]          id_work_q;
   logic [7:0]          len_work_q;
   logic [7:0]          idx_q;
   logic [PayloadW-1:0] buf_q;
   logic                frame_valid_q;
   logic                frame_err_q;
   logic [5:0]          id_q;
   logic [7:0]          len_q;
   logic [PayloadW-1:0] payload_q;

   logic byte_ok;
   logic stuff_pos;
   logic is_hdr;
   logic len_bad;
   logic crc_ok;

   // Byte qualification and decode shared by the FSM and the CRC datapath
   always_comb begin
      byte_ok   = i_en & i_valid;
      // Two AA already seen past the header: this byte is a stuff slot
      stuff_pos = (state_q != StHunt) && (aa_cnt_q == 2'd2);
      is_hdr    = (i_data == HdrByte);
      len_bad   = (i_data > MaxLen);
   end

`ifdef MIN_RX_CRC_EN
   logic [31:0] crc_q;
   logic [31:0] crc_nxt;
   logic [31:0] rx_crc_q;
   logic        crc_init;
   logic        crc_step;
   logic        rx_shift;

   min_crc32_byte u_crc (
      .i_crc  (crc_q),
      .i_byte (i_data),
      .o_crc  (crc_nxt)
   );

   // CRC control: restart on every (re)sync to ID, accumulate CTRL/LEN/payload, shift received CRC
   always_comb begin
      crc_init = byte_ok && is_hdr && (aa_cnt_q == 2'd2);
      crc_step = byte_ok && !stuff_pos &&
                 ((state_q == StId) || (state_q == StData) || ((state_q == StLen) && !len_bad));
      rx_shift = byte_ok && !stuff_pos &&
                 ((state_q == StCrc0) || (state_q == StCrc1) ||
                  (state_q == StCrc2) || (state_q == StCrc3));
   end

   // Running CRC and received CRC (MSB first)
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         crc_q    <= CrcInit;
         rx_crc_q <= '0;
      end else begin
         if (crc_init) begin
            crc_q <= CrcInit;
         end else if (crc_step) begin
            crc_q <= crc_nxt;
         end
         if (rx_shift) begin
            rx_crc_q <= {rx_crc_q[23:0], i_data};
         end
      end
   end

   assign crc_ok = ((crc_q ^ CrcXorOut) == rx_crc_q);
`else
   assign crc_ok = 1'b1;
`endif

   // Frame FSM with registered strobes and last-good-frame outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= StHunt;
         aa_cnt_q      <= '0;
         id_work_q     <= '0;
         len_work_q    <= '0;
         idx_q         <= '0;
         buf_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         id_q          <= '0;
         len_q         <= '0;
         payload_q     <= '0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         if (byte_ok) begin
            if (state_q == StHunt) begin
               if (!is_hdr) begin
                  aa_cnt_q <= '0;
               end else if (aa_cnt_q == 2'd2) begin
                  aa_cnt_q <= '0;
                  buf_q    <= '0;
                  state_q  <= StId;
               end else begin
                  aa_cnt_q <= aa_cnt_q + 2'd1;
               end
            end else if (stuff_pos) begin
               aa_cnt_q <= '0;
               if (is_hdr) begin
                  // Third AA: abort and treat the run as a fresh header
                  frame_err_q <= 1'b1;
                  buf_q       <= '0;
                  state_q     <= StId;
               end else if (i_data != StuffByte) begin
                  frame_err_q <= 1'b1;
                  state_q     <= StHunt;
               end
            end else begin
               aa_cnt_q <= is_hdr ? aa_cnt_q + 2'd1 : 2'd0;
               case (state_q)
                  StId: begin
                     id_work_q <= i_data[5:0];
                     state_q   <= StLen;
                  end
                  StLen: begin
                     if (len_bad) begin
                        frame_err_q <= 1'b1;
                        aa_cnt_q    <= '0;
                        state_q     <= StHunt;
                     end else begin
                        len_work_q <= i_data;
                        idx_q      <= '0;
                        state_q    <= (i_data == 8'd0) ? StCrc0 : StData;
                     end
                  end
                  StData: begin
                     for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
                        if (idx_q == 8'(k)) begin
                           buf_q[8*k +: 8] <= i_data;
                        end
                     end
                     idx_q <= idx_q + 8'd1;
                     if (idx_q == len_work_q - 8'd1) begin
                        state_q <= StCrc0;
                     end
                  end
                  StCrc0: state_q <= StCrc1;
                  StCrc1: state_q <= StCrc2;
                  StCrc2: state_q <= StCrc3;
                  StCrc3: state_q <= StEof;
                  StEof: begin
                     aa_cnt_q <= '0;
                     state_q  <= StHunt;
                     if ((i_data == EofByte) && crc_ok) begin
                        frame_valid_q <= 1'b1;
                        id_q          <= id_work_q;
                        len_q         <= len_work_q;
                        payload_q     <= buf_q;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                  end
                  default: begin
                     aa_cnt_q <= '0;
                     state_q  <= StHunt;
                  end
               endcase
            end
         end
      end
   end

   assign o_frame_valid = frame_valid_q & i_en;
   assign o_frame_err   = frame_err_q & i_en;
   assign o_id          = id_q;
   assign o_len         = len_q;
   assign o_payload     = payload_q;
   assign o_busy        = (state_q != StHunt);

endmodule
